// File: rtl/sysa_drain.sv
// sysa_drain: drains the bottom row of a systolic array into a row FIFO.
//   Purpose : de-skews per-column partial sums and pushes aligned rows.
//   Latency : row r is pushed on the en-cycle k = LAT + r + COLS - 1 and is
//             visible on out_data from the next cycle.
//   Backpressure : valid/ready on the output. A push onto a full FIFO is
//             dropped unless a pop happens in the same cycle, and a drop
//             sets the sticky overflow flag.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   en                   array advance qualifier (same as the PE grid)
//   start, rows          block request and row count (sampled when idle)
//   col_in               bottom-row outputs, column j at [j*DW +: DW]
//   out_valid/ready/data FIFO head, valid/ready handshake
//   busy, done, overflow drain status
module sysa_drain #(
  parameter int COLS  = 4,
  parameter int DW    = 16,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               start,
  input  logic [7:0]         rows,
  input  logic [COLS*DW-1:0] col_in,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [COLS*DW-1:0] out_data,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  localparam int AW = $clog2(DEPTH);
  // First en-cycle count on which column COLS-1 carries row 0.
  localparam logic [9:0] FIRST = 10'(LAT + COLS - 1);

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t             state, state_nx;
  logic [9:0]         k;
  logic [9:0]         k_inc;
  logic [9:0]         last;
  logic [7:0]         rows_q;
  logic               done_q;
  logic               ovf_q;
  logic               accept;
  logic               push_slot;
  logic               finish;
  logic [COLS*DW-1:0] aligned;

  logic [COLS*DW-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        cnt;
  logic               full;
  logic               pop;
  logic               push;

  // ---------------------------------------------------------------------
  // De-skew: column j arrives COLS-1-j en-cycles ahead of the last column,
  // so it is delayed by that many en-qualified stages.
  // ---------------------------------------------------------------------
  for (genvar j = 0; j < COLS; j++) begin : g_col
    localparam int N = COLS - 1 - j;
    if (N == 0) begin : g_thru
      assign aligned[j*DW +: DW] = col_in[j*DW +: DW];
    end else begin : g_dl
      logic [DW-1:0] sr [N];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < N; i++) sr[i] <= '0;
        end else if (en) begin
          sr[0] <= col_in[j*DW +: DW];
          for (int i = 1; i < N; i++) sr[i] <= sr[i-1];
        end
      end
      assign aligned[j*DW +: DW] = sr[N-1];
    end
  end

  // ---------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------
  assign accept = (state == IDLE) && start;
  assign k_inc  = k + 10'd1;
  // Last push slot; rows_q is at most 255 so this never wraps in 10 bits.
  assign last   = 10'(LAT + COLS - 2) + {2'b00, rows_q};

  assign push_slot = (state == DRAIN) && en && (rows_q != 8'd0) &&
                     (k_inc >= FIRST) && (k_inc <= last);
  // An empty block finishes on its first DRAIN cycle regardless of en.
  assign finish    = (state == DRAIN) &&
                     ((rows_q == 8'd0) || (en && (k_inc == last)));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)  state_nx = DRAIN;
      DRAIN:   if (finish) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      k      <= '0;
      rows_q <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= finish;
      if (accept) begin
        k      <= '0;
        rows_q <= rows;
        ovf_q  <= 1'b0;
      end else begin
        if ((state == DRAIN) && en) k <= k_inc;
        if (push_slot && full && !pop) ovf_q <= 1'b1;
      end
    end
  end

  assign busy     = (state == DRAIN);
  assign done     = done_q;
  assign overflow = ovf_q;

  // ---------------------------------------------------------------------
  // Result FIFO. When full, a same-cycle pop frees the slot the write
  // lands in (wr_ptr == rd_ptr), so push-with-pop on full is safe.
  // ---------------------------------------------------------------------
  assign full      = (cnt == (AW+1)'(DEPTH));
  assign out_valid = (cnt != '0);
  assign pop       = out_valid && out_ready;
  assign push      = push_slot && (!full || pop);
  // Storage is not reset, so gate the head with valid to read 0 when empty.
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= aligned;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_sysa_drain.sv
module tb_sysa_drain;

  localparam int COLS  = 4;
  localparam int DW    = 16;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int W     = COLS * DW;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         start;
  logic [7:0]   rows;
  logic [W-1:0] col_in;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         busy;
  logic         done;
  logic         overflow;

  sysa_drain #(.COLS(COLS), .DW(DW), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .start     (start),
    .rows      (rows),
    .col_in    (col_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Bench-side model of the drain, built from the skew/timing contract.
  int           nchk = 0;
  int           nfail = 0;
  int           kk = 0;
  int           cyc = 0;
  int           start_cyc = 0;
  int           done_cnt = 0;
  int           done_rel = -1;
  int           rows_m = 0;
  int           policy = 1;   // 0: ready=1, 1: ready=0, 2: ready only when full
  bit           act = 1'b0;
  bit           ovf_m = 1'b0;
  bit           done_exp = 1'b0;
  logic [W-1:0] q [$];        // scoreboard of rows expected on out_data

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rowval(input int r);
    logic [W-1:0] v;
    v = '0;
    for (int j = 0; j < COLS; j++) v[j*DW +: DW] = DW'(r * 100 + j);
    return v;
  endfunction

  // One clock cycle: drive inputs after the falling edge, sample 1ns later,
  // then advance the model to what the next rising edge should produce.
  task automatic step(input bit en_v, input bit start_v, input int rows_v);
    int kn;
    int hi;
    bit pop_m;
    bit full_m;
    bit act_in;
    @(negedge clk);
    act_in = act;
    en     = en_v;
    start  = start_v;
    rows   = 8'(rows_v);
    kn     = (act && en_v) ? kk + 1 : kk;
    if (en_v) begin
      for (int j = 0; j < COLS; j++) begin
        int r;
        r = kn - LAT - j;
        if (act && r >= 0 && r < rows_m) col_in[j*DW +: DW] = DW'(r * 100 + j);
        else col_in[j*DW +: DW] = DW'(32'hE000 + kn * 16 + j);
      end
    end
    case (policy)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = (q.size() == DEPTH);
    endcase
    #1;
    chk("out_valid", out_valid, q.size() > 0);
    chk("busy", busy, act_in);
    chk("overflow", overflow, ovf_m);
    chk("done", done, done_exp);
    if (done === 1'b1) begin
      done_cnt++;
      done_rel = cyc - start_cyc;
    end
    full_m = (q.size() == DEPTH);
    pop_m  = (q.size() > 0) && out_ready;
    if (pop_m) begin
      chk("out_data", out_data, q[0]);
      void'(q.pop_front());
    end
    hi = LAT + rows_m + COLS - 2;
    if (act && en_v && rows_m > 0 && kn >= LAT + COLS - 1 && kn <= hi) begin
      if (full_m && !pop_m) ovf_m = 1'b1;
      else q.push_back(rowval(kn - LAT - COLS + 1));
    end
    done_exp = 1'b0;
    if (act && (rows_m == 0 || (en_v && kn == hi))) begin
      act      = 1'b0;
      done_exp = 1'b1;
    end
    kk = kn;
    if (start_v && !act_in) begin
      act    = 1'b1;
      kk     = 0;
      rows_m = rows_v;
      ovf_m  = 1'b0;
    end
    cyc++;
  endtask

  task automatic drain(input int n);
    policy = 0;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
  endtask

  // Start a block, run it to completion (bounded), then check done timing.
  task automatic run_block(input int rows_v, input int gap_k, input int gap_len,
                           input int pol, input int restart_n, input int exp_rel);
    int gapped;
    gapped   = 0;
    policy   = pol;
    done_cnt = 0;
    done_rel = -1;
    start_cyc = cyc;
    step(1'b1, 1'b1, rows_v);
    for (int n = 0; n < 300 && act; n++) begin
      bit e;
      bit s;
      int rv;
      e  = 1'b1;
      s  = 1'b0;
      rv = rows_v;
      if (kk == gap_k && gapped < gap_len) begin
        e = 1'b0;
        gapped++;
      end
      if (n == restart_n) begin
        s  = 1'b1;
        rv = 7;
      end
      step(e, s, rv);
    end
    chk("drain_timeout", act, 1'b0);
    step(1'b1, 1'b0, rows_v);
    chk("busy_after_done", busy, 1'b0);
    step(1'b1, 1'b0, rows_v);
    chk("done_count", done_cnt, 1);
    chk("done_cycle", done_rel, exp_rel);
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    start     = 1'b0;
    rows      = 8'd0;
    col_in    = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_overflow", overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic block: three rows, continuous en, always ready.
    run_block(3, -1, 0, 0, -1, 8);
    drain(3);
    chk("basic_empty", q.size(), 0);

    // en held low for three cycles at k=3: same rows, done three cycles later.
    run_block(3, 3, 3, 0, -1, 11);
    drain(3);
    chk("stall_empty", q.size(), 0);

    // Six rows into a four-deep FIFO with no consumer: rows 4,5 dropped.
    run_block(6, -1, 0, 1, -1, 11);
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_stored", q.size(), DEPTH);
    drain(6);
    chk("ovf_empty", q.size(), 0);
    chk("ovf_valid_low", out_valid, 1'b0);

    // Full FIFO with a pop on the push cycle: accepted, no overflow.
    run_block(5, -1, 0, 2, -1, 10);
    chk("full_pop_ovf", overflow, 1'b0);
    drain(6);
    chk("full_pop_empty", q.size(), 0);

    // Empty block, then a start issued mid-drain that must be ignored.
    run_block(0, -1, 0, 0, -1, 2);
    chk("rows0_valid", out_valid, 1'b0);
    run_block(3, -1, 0, 0, 2, 8);
    drain(3);
    chk("restart_empty", q.size(), 0);

    // Reset mid-drain with rows already buffered.
    policy = 1;
    step(1'b1, 1'b1, 3);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 3);
    chk("pre_rst_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_data", out_data, '0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_ovf", overflow, 1'b0);
    q.delete();
    act      = 1'b0;
    kk       = 0;
    done_exp = 1'b0;
    done_cnt = 0;
    step(1'b1, 1'b0, 3);
    step(1'b1, 1'b0, 3);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 3);
    step(1'b1, 1'b0, 3);
    chk("rst_no_done", done_cnt, 0);
    run_block(3, -1, 0, 0, -1, 8);
    drain(3);
    chk("post_rst_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
